tspi_xfer_ctrl: RTL
===================

// Module: tspi_xfer_ctrl
// PURPOSE
//  Sequences one ternary serial transfer over the 3o3 trit link (O_mosi/O_sck/I_miso, 2-bit trits).
//  Accepts a TRITS-trit word on a req/busy/done handshake and shifts it out MS trit first.
//  Drives the ternary sck pattern and samples I_miso into a receive word.
//  Sits between the core and the link pads; it is the only driver of O_mosi/O_sck.
// PARAMETERS
//  TRITS  4  trits per transfer (>=1)
//  DIV    2  I_clk cycles per sck phase (>=1)
// PORTS
//  I_clk      in   1        system clock, all state on posedge
//  I_rst      in   1        asynchronous, active-high reset
//  I_req      in   1        start request, sampled in IDLE only
//  I_tx_data  in   2*TRITS  word to send; trit i = bits [2i+1:2i]
//  O_busy     out  1        transfer in progress
//  O_done     out  1        one-cycle pulse, transfer complete
//  O_rx_data  out  2*TRITS  received word, same packing as I_tx_data
//  O_err      out  1        invalid trit (2'b11) seen on I_miso this transfer
//  O_mosi     out  2        serial data trit
//  O_sck      out  2        serial clock trit
//  I_miso     in   2        serial return trit
// BEHAVIOUR
//  - Trit codes: ZERO=2'b00, PLUS=2'b01, MINUS=2'b10; 2'b11 is invalid.
//  - Reset (async, any state): O_mosi=ZERO, O_sck=ZERO, O_busy=0, O_done=0, O_rx_data=0, O_err=0, FSM=IDLE.
//  - FSM: IDLE -> LEAD -> (PHP -> PHM) x TRITS -> TAIL -> DONE -> IDLE. Each of LEAD/PHP/PHM/TAIL lasts DIV cycles.
//  - IDLE: outputs ZERO, busy=0. If I_req=1 at edge e0: latch I_tx_data, clear rx shift and O_err, busy=1, go to LEAD.
//  - LEAD: O_sck=ZERO, O_mosi=trit TRITS-1 (setup time for the first trit).
//  - PHP: O_sck=PLUS. On its last cycle, sample I_miso into rx shift (LSB side, shift toward MS).
//    If I_miso=2'b11, store ZERO and set O_err (sticky until next accept).
//  - PHM: O_sck=MINUS. At its end, if trits remain, O_mosi <= next lower trit and go to PHP; else go to TAIL.
//  - TAIL: O_sck=ZERO, O_mosi=ZERO.
//  - DONE: at edge e0+DIV*(2*TRITS+2): O_done=1 for 1 cycle, O_rx_data updated, busy=0, same edge.
//    O_rx_data holds until the next DONE.
//  - Latency: I_req accept to O_done rise = DIV*(2*TRITS+2) cycles; back-to-back: I_req held high is re-accepted in the IDLE cycle after DONE.
//  - I_req while busy: ignored, not queued. I_tx_data changes while busy: no effect.
//  - Phase counter: counts 0..DIV-1, wraps on phase change. Trit counter: counts down TRITS-1..0 and must not underflow.
//  - O_err is reported with O_done and held until the next accept.
//  - All outputs registered; no combinational path from I_miso or I_req to any output.
// STRUCTURE
//  - Shared package trit_pkg: trit codes ZERO/PLUS/MINUS/INVALID, FSM state encodings.
//  - Sub-module tspi_phase_timer: DIV-cycle phase counter.
//    In: enable and restart. Out: last-cycle strobe.
//  - Top: FSM, tx/rx shift registers, trit counter, err flag.
// TESTING (TRITS=4, DIV=2 unless noted)
//  - Reset mid-transfer: assert I_rst during a PHP phase.
//    -> outputs ZERO/0 immediately, without waiting for a clock edge.
//    -> next I_req starts a clean transfer with O_err=0.
//  - Loopback (I_miso=O_mosi), tx=8'h61 {PLUS,MINUS,ZERO,PLUS}:
//    -> O_sck sequence ZERO x2, (PLUS x2, MINUS x2) x4, ZERO x2.
//    -> O_done 20 cycles after accept; O_rx_data=8'h61; O_err=0.
//  - I_miso forced 2'b11 on trit 2 only, others PLUS:
//    -> O_rx_data=8'b01_00_01_01 (8'h45); O_err=1 at done; O_err cleared on next accept.
//  - I_req pulsed mid-transfer:
//    -> ignored; exactly one O_done.
//  - I_req held high for 3 transfers:
//    -> O_done pulses exactly 21 cycles apart; busy low for 1 cycle between transfers.
//  - DIV=1, TRITS=1, tx=MINUS, I_miso=PLUS:
//    -> O_done 4 cycles after accept; O_rx_data=2'b01.

Source files
------------

// File: rtl/trit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trit_pkg : trit codes and transfer-controller state encodings               |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package trit_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_ZERO    = 2'b00;
    localparam trit_t TRIT_PLUS    = 2'b01;
    localparam trit_t TRIT_MINUS   = 2'b10;
    localparam trit_t TRIT_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEAD = 3'd1,
        ST_PHP  = 3'd2,
        ST_PHM  = 3'd3,
        ST_TAIL = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // The invalid code is folded to ZERO before it enters the receive word.
    function automatic trit_t trit_clean(input trit_t t);
        return (t == TRIT_INVALID) ? TRIT_ZERO : t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tspi_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tspi_phase_timer : DIV-cycle phase counter with last-cycle strobe           |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tspi_phase_timer #(
    parameter int DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic restart_i,
    output logic last_o
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (restart_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign last_o = en_i && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/tspi_xfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tspi_xfer_ctrl : sequences one ternary serial transfer on the trit link     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tspi_xfer_ctrl
    import trit_pkg::*;
#(
    parameter int TRITS = 4,
    parameter int DIV   = 2
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_req,
    input  logic [2*TRITS-1:0]   I_tx_data,
    output logic                 O_busy,
    output logic                 O_done,
    output logic [2*TRITS-1:0]   O_rx_data,
    output logic                 O_err,
    output logic [1:0]           O_mosi,
    output logic [1:0]           O_sck,
    input  logic [1:0]           I_miso
);

    localparam int W  = 2 * TRITS;
    localparam int TW = (TRITS > 1) ? $clog2(TRITS) : 1;

    state_t          state_q;
    logic [W-1:0]    tx_q;
    logic [W-1:0]    rx_q;
    logic [W-1:0]    rx_data_q;
    logic [TW-1:0]   trit_cnt_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            err_seen_q;
    trit_t           mosi_q;
    trit_t           sck_q;

    logic            accept_d;
    logic            phase_en_d;
    logic            phase_last;
    logic [W-1:0]    tx_d;
    logic [W-1:0]    rx_d;

    assign accept_d   = I_req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign phase_en_d = (state_q == ST_LEAD) || (state_q == ST_PHP) ||
                        (state_q == ST_PHM)  || (state_q == ST_TAIL);
    assign tx_d       = tx_q << 2;
    assign rx_d       = (rx_q << 2) | W'(trit_clean(I_miso));

    tspi_phase_timer #(
        .DIV (DIV)
    ) u_phase_timer (
        .clk_i     (I_clk),
        .rst_i     (I_rst),
        .en_i      (phase_en_d),
        .restart_i (accept_d),
        .last_o    (phase_last)
    );

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            trit_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_seen_q <= 1'b0;
            mosi_q     <= TRIT_ZERO;
            sck_q      <= TRIT_ZERO;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // DONE accepts like IDLE so a held request restarts one cycle after done.
                ST_IDLE, ST_DONE: begin
                    if (I_req) begin
                        tx_q       <= tx_d_from(I_tx_data);
                        mosi_q     <= I_tx_data[W-1 -: 2];
                        rx_q       <= '0;
                        err_seen_q <= 1'b0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        trit_cnt_q <= TW'(TRITS - 1);
                        state_q    <= ST_LEAD;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_LEAD: begin
                    if (phase_last) begin
                        sck_q   <= TRIT_PLUS;
                        state_q <= ST_PHP;
                    end
                end
                ST_PHP: begin
                    if (phase_last) begin
                        rx_q    <= rx_d;
                        if (I_miso == TRIT_INVALID) begin
                            err_seen_q <= 1'b1;
                        end
                        sck_q   <= TRIT_MINUS;
                        state_q <= ST_PHM;
                    end
                end
                ST_PHM: begin
                    if (phase_last) begin
                        if (trit_cnt_q != '0) begin
                            trit_cnt_q <= trit_cnt_q - 1'b1;
                            mosi_q     <= tx_q[W-1 -: 2];
                            tx_q       <= tx_d;
                            sck_q      <= TRIT_PLUS;
                            state_q    <= ST_PHP;
                        end else begin
                            mosi_q     <= TRIT_ZERO;
                            sck_q      <= TRIT_ZERO;
                            state_q    <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: begin
                    if (phase_last) begin
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        rx_data_q <= rx_q;
                        err_q     <= err_seen_q;
                        state_q   <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The MS trit goes straight to O_mosi, so the shift register keeps the rest.
    function automatic logic [W-1:0] tx_d_from(input logic [W-1:0] word);
        return word << 2;
    endfunction

    assign O_busy    = busy_q;
    assign O_done    = done_q;
    assign O_rx_data = rx_data_q;
    assign O_err     = err_q;
    assign O_mosi    = mosi_q;
    assign O_sck     = sck_q;

endmodule
`default_nettype wire
